// File: rtl/error_reporter_pkg.sv
// Shared definitions for the error reporter: FSM states, report constants,
// error-source bit positions and the reset-assert level.

`ifndef ERROR_REPORTER_RST_ACTIVE
`define ERROR_REPORTER_RST_ACTIVE 1'b1
`endif

package error_reporter_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SEND_HDR  = 3'd1,
        SEND_MASK = 3'd2,
        SEND_TS   = 3'd3,
        WAIT_CLR  = 3'd4
    } state_e;

    localparam logic [7:0] REPORT_MAGIC = 8'hE5;

    // Width of the source index and the popcount fields in the header word.
    localparam int ID_W = 4;

    localparam int ERR_SRC_INST_CACHE = 0;
    localparam int ERR_SRC_DATA_CACHE = 1;
    localparam int ERR_SRC_IF         = 2;
    localparam int ERR_SRC_ID         = 3;
    localparam int ERR_SRC_LAUNCH     = 4;
    localparam int ERR_SRC_EX         = 5;
    localparam int ERR_SRC_MM         = 6;
    localparam int ERR_SRC_MEM        = 7;
    localparam int ERR_SRC_WB         = 8;

    // Report word presented while in a given state; zero outside SEND_*.
    function automatic logic [31:0] build_word(
        input state_e          st,
        input logic [ID_W-1:0] id,
        input logic [ID_W-1:0] cnt,
        input logic [31:0]     mask,
        input logic [31:0]     ts
    );
        logic [31:0] w;
        case (st)
            SEND_HDR:  w = {REPORT_MAGIC, id, cnt, 16'h0000};
            SEND_MASK: w = mask;
            SEND_TS:   w = ts;
            default:   w = 32'h0000_0000;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/err_prio_enc.sv
// Lowest-set-bit index and population count over the error flag vector.

module err_prio_enc
    import error_reporter_pkg::*;
#(
    parameter int NUM_SRC = 9
) (
    input  logic [NUM_SRC-1:0] vec_i,
    output logic [ID_W-1:0]    idx_o,
    output logic [ID_W-1:0]    cnt_o
);

    // Scan high to low so the lowest set bit is the last one written.
    always_comb begin
        idx_o = '0;
        cnt_o = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o = ID_W'(i);
            end
        end
        for (int i = 0; i < NUM_SRC; i++) begin
            cnt_o = cnt_o + ID_W'(vec_i[i]);
        end
    end

endmodule

// File: rtl/error_reporter.sv
// Captures the first error event, raises halt, streams a three-word report
// (header, mask, timestamp) over valid/ready and waits for a clear.

module error_reporter
    import error_reporter_pkg::*;
#(
    parameter int NUM_SRC = 9,
    parameter int TS_W    = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] error_vec_i,
    output logic               halt_req_o,
    output logic               report_valid_o,
    output logic [31:0]        report_data_o,
    input  logic               report_ready_i,
    input  logic               clear_i,
    output logic               busy_o
);

    state_e             state_q, state_d;
    logic [TS_W-1:0]    ts_q, ts_d;
    logic [TS_W-1:0]    ts_cap_q, ts_cap_d;
    logic [NUM_SRC-1:0] first_mask_q, first_mask_d;
    logic [NUM_SRC-1:0] late_q, late_d;
    logic [ID_W-1:0]    first_id_q, first_id_d;
    logic [ID_W-1:0]    cnt_q, cnt_d;
    logic               halt_q, valid_q;
    logic [31:0]        data_q;

    logic [NUM_SRC-1:0] cap_src;
    logic [ID_W-1:0]    enc_idx, enc_cnt;
    logic               xfer;
    logic               capture;

    // In IDLE the live flags are captured; on a clear, whatever piled up
    // during the report is folded in with the live flags and recaptured.
    assign cap_src = (state_q == IDLE) ? error_vec_i : (late_q | error_vec_i);
    assign xfer    = valid_q & report_ready_i;

    err_prio_enc #(
        .NUM_SRC (NUM_SRC)
    ) u_prio_enc (
        .vec_i (cap_src),
        .idx_o (enc_idx),
        .cnt_o (enc_cnt)
    );

    // Next-state, capture and late-error accumulation.
    always_comb begin
        state_d      = state_q;
        ts_d         = ts_q + TS_W'(1);
        ts_cap_d     = ts_cap_q;
        first_mask_d = first_mask_q;
        first_id_d   = first_id_q;
        cnt_d        = cnt_q;
        late_d       = late_q;
        capture      = 1'b0;

        if (state_q != IDLE) begin
            late_d = late_q | error_vec_i;
        end

        case (state_q)
            IDLE: begin
                if (|error_vec_i) begin
                    capture = 1'b1;
                    state_d = SEND_HDR;
                end
            end
            SEND_HDR: begin
                if (xfer) state_d = SEND_MASK;
            end
            SEND_MASK: begin
                if (xfer) state_d = SEND_TS;
            end
            SEND_TS: begin
                if (xfer) state_d = WAIT_CLR;
            end
            WAIT_CLR: begin
                if (clear_i) begin
                    if (|cap_src) begin
                        capture = 1'b1;
                        state_d = SEND_HDR;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (capture) begin
            first_mask_d = cap_src;
            first_id_d   = enc_idx;
            cnt_d        = enc_cnt;
            ts_cap_d     = ts_q;
            late_d       = '0;
        end
    end

    // State and capture registers; outputs are registered from next-state so
    // the word appears with valid and holds while ready is low.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n == `ERROR_REPORTER_RST_ACTIVE) begin
            state_q      <= IDLE;
            ts_q         <= '0;
            ts_cap_q     <= '0;
            first_mask_q <= '0;
            first_id_q   <= '0;
            cnt_q        <= '0;
            late_q       <= '0;
            halt_q       <= 1'b0;
            valid_q      <= 1'b0;
            data_q       <= '0;
        end else begin
            state_q      <= state_d;
            ts_q         <= ts_d;
            ts_cap_q     <= ts_cap_d;
            first_mask_q <= first_mask_d;
            first_id_q   <= first_id_d;
            cnt_q        <= cnt_d;
            late_q       <= late_d;
            halt_q       <= (state_d != IDLE);
            valid_q      <= (state_d == SEND_HDR) || (state_d == SEND_MASK) ||
                            (state_d == SEND_TS);
            data_q       <= build_word(state_d, first_id_d, cnt_d,
                                       32'(first_mask_d), 32'(ts_cap_d));
        end
    end

    assign halt_req_o     = halt_q;
    assign report_valid_o = valid_q;
    assign report_data_o  = data_q;
    assign busy_o         = (state_q != IDLE);

endmodule

// File: doc/error_reporter.md
# error_reporter

Consumer side of the CPU error-flag path. It takes the per-source error flags that the pipeline stages and caches raise, captures the first failing event, and requests a pipeline halt. It then streams a three-word error report to the debug port over a valid/ready handshake and holds the halt until software or the debug host acknowledges with a clear. It sits between the stage/cache error outputs and the SoC debug/trace interface.

## Interface
Parameters:
- NUM_SRC, 9: number of error sources. Supported range is 1..15.
- TS_W, 32: width of the free-running timestamp counter. Supported range is 1..32.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-high reset (asserted = 1).
- error_vec_i  in  NUM_SRC  error flags, level-sampled every cycle. Bit mapping: 0 inst_cache, 1 data_cache, 2 if, 3 id, 4 launch, 5 ex, 6 mm, 7 mem, 8 wb.
- halt_req_o  out  1  pipeline halt request. Registered.
- report_valid_o  out  1  report word valid. Registered.
- report_data_o  out  32  report word.
- report_ready_i  in  1  debug port accepts the word.
- clear_i  in  1  error acknowledge pulse. Honored only in WAIT_CLR.
- busy_o  out  1  high in any state other than IDLE.

## Operation
- Timestamp counter ts:
  - Free-running, TS_W bits, +1 every cycle.
  - Wraps from all-ones to 0. No saturation.
- Capture, in IDLE when error_vec_i != 0:
  - first_mask <= error_vec_i.
  - first_id <= index of the lowest set bit.
  - cnt <= popcount(error_vec_i).
  - ts_cap <= ts of that cycle.
  - late_mask <= 0.
  - Next state is SEND_HDR.
- Late errors: in every non-IDLE state, late_mask <= late_mask | error_vec_i.
- Report words, zero-filled where unspecified:
  - HDR: [31:24]=8'hE5, [23:20]=first_id, [19:16]=cnt, [15:0]=0.
  - MASK: [NUM_SRC-1:0]=first_mask, upper bits 0.
  - TS: ts_cap, zero-extended to 32 bits.
- FSM:
  - IDLE -> SEND_HDR on an error.
  - SEND_HDR -> SEND_MASK on handshake.
  - SEND_MASK -> SEND_TS on handshake.
  - SEND_TS -> WAIT_CLR on handshake.
  - WAIT_CLR on clear_i:
    - If (late_mask | error_vec_i) == 0: go to IDLE.
    - Otherwise: recapture from (late_mask | error_vec_i), with ts_cap = ts of the clear cycle and late_mask <= 0, and go to SEND_HDR.
- Handshake rules:
  - A transfer happens on a cycle where report_valid_o & report_ready_i.
  - While valid is high and ready is low, report_data_o is held stable.
  - report_valid_o is high exactly in the SEND_* states.
  - report_data_o is 0 whenever valid is low.
- clear_i outside WAIT_CLR is ignored and has no side effect.
- halt_req_o is high in every state except IDLE.
- rst_n asserted at any time, including mid-report:
  - state goes to IDLE; all registers and outputs go to 0.
  - An in-flight word is abandoned. No partial-word guarantee.

## Timing
- Reset values: halt_req_o=0, report_valid_o=0, report_data_o=0, busy_o=0, ts=0.
- Error sampled in cycle N:
  - halt_req_o=1 and report_valid_o=1 with HDR from cycle N+1.
  - With report_ready_i held at 1: HDR at N+1, MASK at N+2, TS at N+3, WAIT_CLR from N+4.
- Each cycle of ready=0 in a SEND state adds one cycle of latency.
- clear_i at cycle M in WAIT_CLR, no pending errors: IDLE and halt_req_o=0 at M+1.
- clear_i at M with pending errors: halt stays high, and HDR is valid at M+1.
- The minimum report is 3 cycles. There is no combinational path from error_vec_i or report_ready_i to any output.

## Structure
- Shared header/package holds:
  - state encoding: IDLE, SEND_HDR, SEND_MASK, SEND_TS, WAIT_CLR;
  - magic constant 8'hE5;
  - source index constants (ERR_SRC_INST_CACHE = 0 … ERR_SRC_WB = 8);
  - the reset-enable define.
- One sub-module, err_prio_enc: combinational lowest-set-bit index plus popcount over NUM_SRC bits. It is used for both capture paths.

## Test plan
- Reset: hold rst_n=1 for 3 cycles, then release -> all outputs 0; ts counts 0,1,2…
- Single error: error_vec_i=9'h020 at ts=100, ready=1 -> words 0xE5510000, 0x00000020, 0x00000064 on consecutive cycles; halt from the next cycle; clear -> IDLE.
- Multiple errors with backpressure: error_vec_i=9'h10C, ready toggling 0/1 -> HDR 0xE5230000, MASK 0x0000010C; each word held stable while ready=0.
- Late error plus clear:
  - bit 8 rises during SEND_MASK, clear in WAIT_CLR -> second report HDR 0xE5810000, MASK 0x100, TS = ts at the clear cycle;
  - halt never drops between the two reports.
- Ignored clear and wrap-around:
  - clear_i pulsed during SEND_HDR -> no effect;
  - TS_W=4, error at ts=15 -> TS word 0x0000000F, and the next ts value is 0.
- Mid-report reset: assert rst_n during SEND_MASK -> next cycle all outputs 0, state IDLE; a new error produces a fresh HDR.
